// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for an AES-128 encryption datapath.
// Steps through ARK0, then KEY/SUB/SHIFT/MIX/ARK per round (MIX skipped in
// the last round), raising one stage enable at a time and waiting for that
// stage's done. A done is ignored in the first cycle of every state.
// Optional stage watchdog: define AES_STAGE_TIMEOUT_EN to enable it.
module aes_round_ctrl #(
  parameter int NR             = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       pi_clk,
  input  logic       pi_rst,
  input  logic       pi_start,
  input  logic       pi_key_done,
  input  logic       pi_sub_done,
  input  logic       pi_shift_done,
  input  logic       pi_mix_done,
  input  logic       pi_ark_done,
  output logic       po_key_en,
  output logic       po_sub_en,
  output logic       po_shift_en,
  output logic       po_mix_en,
  output logic       po_ark_en,
  output logic       po_sel_init,
  output logic [3:0] po_round,
  output logic       po_busy,
  output logic       po_done,
  output logic       po_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARK0, S_KEY, S_SUB, S_SHIFT, S_MIX, S_ARK, S_DONE, S_ERR
  } state_e;

  localparam logic [3:0] LP_NR = 4'(NR);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic       r_first;
  logic       w_stage;
  logic       w_stage_done;
  logic       w_acc;
  logic       w_tmo;
  logic       r_key_en;
  logic       r_sub_en;
  logic       r_shift_en;
  logic       r_mix_en;
  logic       r_ark_en;
  logic       r_sel_init;
  logic       r_busy;
  logic       r_done;

  // Select the done that belongs to the current stage state; others are ignored
  always_comb begin
    w_stage      = 1'b1;
    w_stage_done = 1'b0;
    case (r_state)
      S_ARK0:  w_stage_done = pi_ark_done;
      S_KEY:   w_stage_done = pi_key_done;
      S_SUB:   w_stage_done = pi_sub_done;
      S_SHIFT: w_stage_done = pi_shift_done;
      S_MIX:   w_stage_done = pi_mix_done;
      S_ARK:   w_stage_done = pi_ark_done;
      default: w_stage      = 1'b0;
    endcase
  end

  // r_first marks the settle cycle, so a stale done cannot advance the FSM
  assign w_acc = w_stage && !r_first && w_stage_done;

`ifdef AES_STAGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_error;

  // Cycles spent in the current stage state; cleared on every state change
  always_ff @(posedge pi_clk) begin
    if (pi_rst || (w_next != r_state)) begin
      r_tcnt <= '0;
    end else if (w_stage) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_tmo    = w_stage && !w_acc && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign po_error = r_error;
`else
  assign w_tmo    = 1'b0;
  assign po_error = 1'b0;
`endif

  // Next-state and next-round decision
  always_comb begin
    w_next      = r_state;
    w_round_nxt = r_round;
    case (r_state)
      S_IDLE: begin
        if (pi_start) begin
          w_next      = S_ARK0;
          w_round_nxt = '0;
        end
      end
      S_ARK0: begin
        if (w_acc) begin
          w_next      = S_KEY;
          w_round_nxt = 4'd1;
        end
      end
      S_KEY:   if (w_acc) w_next = S_SUB;
      S_SUB:   if (w_acc) w_next = S_SHIFT;
      S_SHIFT: if (w_acc) w_next = (r_round < LP_NR) ? S_MIX : S_ARK;
      S_MIX:   if (w_acc) w_next = S_ARK;
      S_ARK: begin
        if (w_acc) begin
          if (r_round == LP_NR) begin
            w_next = S_DONE;
          end else begin
            w_next      = S_KEY;
            w_round_nxt = r_round + 4'd1;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_ERR;
  end

  // FSM register; outputs are decoded from the next state so they line up
  // with the state they describe
  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      r_state    <= S_IDLE;
      r_round    <= '0;
      r_first    <= 1'b1;
      r_key_en   <= 1'b0;
      r_sub_en   <= 1'b0;
      r_shift_en <= 1'b0;
      r_mix_en   <= 1'b0;
      r_ark_en   <= 1'b0;
      r_sel_init <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef AES_STAGE_TIMEOUT_EN
      r_error    <= 1'b0;
`endif
    end else begin
      r_state    <= w_next;
      r_round    <= w_round_nxt;
      r_first    <= (w_next != r_state);
      r_key_en   <= (w_next == S_KEY);
      r_sub_en   <= (w_next == S_SUB);
      r_shift_en <= (w_next == S_SHIFT);
      r_mix_en   <= (w_next == S_MIX);
      r_ark_en   <= (w_next == S_ARK0) || (w_next == S_ARK);
      r_sel_init <= (w_next == S_ARK0);
      r_busy     <= (w_next inside {S_ARK0, S_KEY, S_SUB, S_SHIFT, S_MIX, S_ARK});
      r_done     <= (w_next == S_DONE);
`ifdef AES_STAGE_TIMEOUT_EN
      r_error    <= (w_next == S_ERR);
`endif
    end
  end

  assign po_key_en   = r_key_en;
  assign po_sub_en   = r_sub_en;
  assign po_shift_en = r_shift_en;
  assign po_mix_en   = r_mix_en;
  assign po_ark_en   = r_ark_en;
  assign po_sel_init = r_sel_init;
  assign po_round    = r_round;
  assign po_busy     = r_busy;
  assign po_done     = r_done;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Round sequencer for the AES-128 encryption datapath.
- Drives per-stage enables for key expansion, sub_bytes, shift_rows, mix_columns and add_round_key, and waits on each stage's done before moving on.
- Tracks the round number, skips mix_columns in the final round, and reports busy, done and error to the top-level core.
- Holds no data; it owns sequencing only.

Parameters:
- NR, 10, number of rounds; legal range 1..15.
- TIMEOUT_CYCLES, 64, maximum cycles in one stage state before an error. Used only with AES_STAGE_TIMEOUT_EN.

Ports:
- pi_clk  in  1  clock; all logic on the rising edge.
- pi_rst  in  1  synchronous, active-high reset.
- pi_start  in  1  start request; sampled only in IDLE.
- pi_key_done  in  1  key expansion stage done.
- pi_sub_done  in  1  sub_bytes stage done.
- pi_shift_done  in  1  shift_rows stage done.
- pi_mix_done  in  1  mix_columns stage done.
- pi_ark_done  in  1  add_round_key stage done.
- po_key_en  out  1  key expansion enable (level).
- po_sub_en  out  1  sub_bytes enable (level).
- po_shift_en  out  1  shift_rows enable (level).
- po_mix_en  out  1  mix_columns enable (level).
- po_ark_en  out  1  add_round_key enable (level).
- po_sel_init  out  1  1 = add_round_key takes plaintext/key0 (round 0).
- po_round  out  4  current round number, 0..NR.
- po_busy  out  1  sequence in progress.
- po_done  out  1  one-cycle pulse when encryption completes.
- po_error  out  1  sticky stage-timeout flag.

Behaviour:
- Reset: synchronous on pi_rst, checked at every edge. It overrides all other logic, including mid-sequence.
- Reset values: state=IDLE, all enables 0, po_round=0, po_sel_init=0, po_busy=0, po_done=0, po_error=0.
- All outputs are registered and decoded from state and the round counter.
- States: IDLE, ARK0, KEY, SUB, SHIFT, MIX, ARK, DONE, ERR.
- IDLE: pi_start=1 -> ARK0 with po_round=0 and po_busy=1. Otherwise stay.
- ARK0: po_ark_en=1, po_sel_init=1. On accepted pi_ark_done: po_round=1, -> KEY.
- KEY: po_key_en=1. Accepted done -> SUB.
- SUB: po_sub_en=1. Accepted done -> SHIFT.
- SHIFT: po_shift_en=1. Accepted done -> MIX if po_round<NR, else -> ARK.
- MIX: po_mix_en=1. Accepted done -> ARK.
- ARK: po_ark_en=1, po_sel_init=0. On accepted done:
  - po_round==NR -> DONE;
  - otherwise po_round increments by 1 and the next state is KEY.
- DONE: po_done=1 for exactly one cycle, po_busy=0; next state IDLE. po_round holds NR until the next start.
- Enable rules:
  - Exactly one stage enable is high in any stage state; none in IDLE, DONE or ERR.
  - An enable stays high for every cycle of its state and drops at the same edge the state is left.
- Done acceptance:
  - Only the done matching the current state is considered. Dones from other stages are ignored.
  - A done is ignored in the first cycle of each state (settle cycle), so a stale done from a stage that was just deasserted cannot advance the FSM.
  - Minimum stage-state length is therefore 2 cycles.
- pi_start outside IDLE is ignored; there is no queuing.
- po_busy=1 in ARK0, KEY, SUB, SHIFT, MIX and ARK; 0 otherwise.
- The round counter never wraps: its maximum value is NR, which is at most 15.

Optional Feature:
- Macro: AES_STAGE_TIMEOUT_EN.
- When defined:
  - A stage cycle counter clears on every state entry and increments each cycle in a stage state.
  - If it reaches TIMEOUT_CYCLES with no accepted done, the FSM goes to ERR.
  - ERR: po_error=1, po_busy=0, all enables 0. It is left only by pi_rst; pi_start is ignored.
- When undefined: no counter, ERR is unreachable, and po_error is tied to 0. The FSM waits indefinitely for each done.

Test Plan:
- Bench stage model (used unless stated): each stage asserts done in the 3rd cycle its enable is high (a 3-cycle state) and holds done while the enable is high.
- Nominal run, NR=10: pi_start pulse in IDLE -> po_done pulse 150 cycles after the first ARK0 cycle.
  - Cycle count: 3 + 9x15 + 12.
  - po_mix_en rises 9 times total, never while po_round=10.
  - po_sel_init=1 only in the first 3 cycles.
- Stale and crossed dones: hold pi_mix_done=1 permanently. The FSM advances out of MIX only after its settle cycle, and SUB/KEY/ARK ignore pi_mix_done. Result: MIX lasts 2 cycles and total latency drops by 9.
- Reset mid-run: assert pi_rst for one cycle while in SHIFT of round 5. Next cycle: IDLE, po_round=0, all enables 0, po_busy=0, no po_done.
- Start during busy: pulse pi_start in round 3. There is no restart and no extra run, and po_done pulses exactly once at cycle 150.
- AES_STAGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8: never assert pi_sub_done. Result: po_error=1 and po_sub_en=0 after 8 cycles in SUB; the FSM stays in ERR despite pi_start and leaves only on pi_rst.
